// File: rtl/sctag_jbi_iq.sv
// JBI->L2 request deframer with credit-managed input queue, plus 64-bit read-return serializer.
// Optional macro JBI_IQ_ECC_CHK_EN enables SEC/DED checking of write-data beats.
module sctag_jbi_iq #(
    parameter int IQ_DEPTH = 4
) (
    input  logic        rclk,
    input  logic        arst_l,
    input  logic        jbi_sctag_req_vld,
    input  logic [31:0] jbi_sctag_req,
    input  logic [6:0]  jbi_scbuf_ecc,
    output logic        sctag_jbi_iq_dequeue,
    output logic        iq_vld,
    input  logic        iq_rdy,
    output logic [1:0]  iq_opcode,
    output logic [11:0] iq_ctag,
    output logic [31:0] iq_addr,
    output logic [63:0] iq_wdata,
    output logic        iq_ecc_err,
    output logic        iq_ovf_err,
    input  logic        rtn_vld,
    output logic        rtn_rdy,
    input  logic [11:0] rtn_ctag,
    input  logic [63:0] rtn_data,
    input  logic        rtn_ue,
    output logic        scbuf_jbi_ctag_vld,
    output logic [31:0] scbuf_jbi_data,
    output logic        scbuf_jbi_ue_err
);
    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_DHI, RX_DLO} rx_state_t;
    typedef enum logic [1:0] {RT_IDLE, RT_HDR, RT_HI, RT_LO} rt_state_t;
    typedef struct packed {
        logic [1:0]  opcode;
        logic [11:0] ctag;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        ecc_err;
    } entry_t;

    rx_state_t   rx_state;
    logic [1:0]  hdr_opcode;
    logic [11:0] hdr_ctag;
    logic [31:0] rx_addr;
    logic [31:0] rx_whi;
    logic        rx_err_hi;
    logic        beat_ecc_err;

    entry_t          mem [IQ_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [1:0]      credit_owed;
    logic [2:0]      credit_total;

    logic   last_beat, enq_frame, rsv_done, pop, full, do_enq;
    entry_t new_entry, head;

`ifdef JBI_IQ_ECC_CHK_EN
    logic [6:0]  gen_ecc;
    logic [31:0] unused_gen_dout;
    zzecc_sctag_pgen_32b u_pgen (.dout(unused_gen_dout), .parity(gen_ecc), .din(jbi_sctag_req));
    assign beat_ecc_err = (gen_ecc != jbi_scbuf_ecc);
`else
    logic unused_ecc;
    assign unused_ecc   = ^jbi_scbuf_ecc;
    assign beat_ecc_err = 1'b0;
`endif

    assign last_beat = jbi_sctag_req_vld &&
                       ((rx_state == RX_ADDR && hdr_opcode != 2'b01) || rx_state == RX_DLO);
    assign enq_frame = last_beat && !hdr_opcode[1];
    assign rsv_done  = last_beat && hdr_opcode[1];
    assign pop       = iq_vld && iq_rdy;
    assign full      = (count == CW'(IQ_DEPTH));
    // A pop on the same edge frees the slot the arriving frame needs.
    assign do_enq    = enq_frame && (!full || pop);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        new_entry        = '0;
        new_entry.opcode = hdr_opcode;
        new_entry.ctag   = hdr_ctag;
        if (rx_state == RX_DLO) begin
            new_entry.addr    = rx_addr;
            new_entry.wdata   = {rx_whi, jbi_sctag_req};
            new_entry.ecc_err = rx_err_hi | beat_ecc_err;
        end else begin
            new_entry.addr = jbi_sctag_req;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            rx_state   <= RX_IDLE;
            hdr_opcode <= '0;
            hdr_ctag   <= '0;
            rx_addr    <= '0;
            rx_whi     <= '0;
            rx_err_hi  <= 1'b0;
        end else if (jbi_sctag_req_vld) begin
            unique case (rx_state)
                RX_IDLE: begin
                    hdr_opcode <= jbi_sctag_req[31:30];
                    hdr_ctag   <= jbi_sctag_req[29:18];
                    rx_state   <= RX_ADDR;
                end
                RX_ADDR: begin
                    rx_addr  <= jbi_sctag_req;
                    rx_state <= (hdr_opcode == 2'b01) ? RX_DHI : RX_IDLE;
                end
                RX_DHI: begin
                    rx_whi    <= jbi_sctag_req;
                    rx_err_hi <= beat_ecc_err;
                    rx_state  <= RX_DLO;
                end
                RX_DLO: rx_state <= RX_IDLE;
            endcase
        end
    end

    // NOTE: queue storage is not reset; outputs are gated by iq_vld so stale entries never show.
    always_ff @(posedge rclk) begin
        if (do_enq) mem[wr_ptr] <= new_entry;
    end

    assign credit_total = {1'b0, credit_owed} + {2'b0, pop} + {2'b0, rsv_done};

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            iq_ovf_err           <= 1'b0;
            credit_owed          <= '0;
            sctag_jbi_iq_dequeue <= 1'b0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            if (do_enq && !pop)      count <= count + CW'(1);
            else if (pop && !do_enq) count <= count - CW'(1);
            if (enq_frame && full && !pop) iq_ovf_err <= 1'b1;
            // Credits are owed, never merged: one pulse per cycle until the backlog drains.
            if (credit_total != 3'd0) begin
                sctag_jbi_iq_dequeue <= 1'b1;
                credit_owed          <= 2'(credit_total - 3'd1);
            end else begin
                sctag_jbi_iq_dequeue <= 1'b0;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign iq_vld     = (count != '0);
    assign iq_opcode  = iq_vld ? head.opcode  : '0;
    assign iq_ctag    = iq_vld ? head.ctag    : '0;
    assign iq_addr    = iq_vld ? head.addr    : '0;
    assign iq_wdata   = iq_vld ? head.wdata   : '0;
    assign iq_ecc_err = iq_vld ? head.ecc_err : 1'b0;

    rt_state_t   rt_state;
    logic [63:0] rt_data;
    logic        rt_ue;

    assign rtn_rdy = (rt_state == RT_IDLE) || (rt_state == RT_LO);

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            rt_state           <= RT_IDLE;
            rt_data            <= '0;
            rt_ue              <= 1'b0;
            scbuf_jbi_ctag_vld <= 1'b0;
            scbuf_jbi_data     <= '0;
            scbuf_jbi_ue_err   <= 1'b0;
        end else if (rtn_vld && rtn_rdy) begin
            rt_state           <= RT_HDR;
            rt_data            <= rtn_data;
            rt_ue              <= rtn_ue;
            scbuf_jbi_ctag_vld <= 1'b1;
            scbuf_jbi_data     <= {20'b0, rtn_ctag};
            scbuf_jbi_ue_err   <= 1'b0;
        end else begin
            scbuf_jbi_ctag_vld <= 1'b0;
            unique case (rt_state)
                RT_HDR: begin
                    rt_state         <= RT_HI;
                    scbuf_jbi_data   <= rt_data[63:32];
                    scbuf_jbi_ue_err <= rt_ue;
                end
                RT_HI: begin
                    rt_state         <= RT_LO;
                    scbuf_jbi_data   <= rt_data[31:0];
                    scbuf_jbi_ue_err <= rt_ue;
                end
                default: begin
                    rt_state         <= RT_IDLE;
                    scbuf_jbi_data   <= '0;
                    scbuf_jbi_ue_err <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sctag_jbi_iq.sv
// Scoreboard bench for sctag_jbi_iq: expected IQ entries and return beats queued at drive time.
module tb_sctag_jbi_iq;
    localparam int IQ_DEPTH = 4;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [11:0] ctag;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        ecc_err;
    } entry_t;
    typedef struct packed {
        logic        vld;
        logic [31:0] data;
        logic        ue;
    } beat_t;

    logic        rclk = 1'b0;
    logic        arst_l = 1'b0;
    logic        jbi_sctag_req_vld = 1'b0;
    logic [31:0] jbi_sctag_req = '0;
    logic [6:0]  jbi_scbuf_ecc = '0;
    logic        sctag_jbi_iq_dequeue, iq_vld, iq_ecc_err, iq_ovf_err;
    logic        iq_rdy = 1'b0;
    logic [1:0]  iq_opcode;
    logic [11:0] iq_ctag;
    logic [31:0] iq_addr;
    logic [63:0] iq_wdata;
    logic        rtn_vld = 1'b0;
    logic        rtn_rdy;
    logic [11:0] rtn_ctag = '0;
    logic [63:0] rtn_data = '0;
    logic        rtn_ue = 1'b0;
    logic        scbuf_jbi_ctag_vld, scbuf_jbi_ue_err;
    logic [31:0] scbuf_jbi_data;

    entry_t exp_q[$];
    entry_t obs_q[$];
    beat_t  ret_q[$];
    int     errors = 0;
    int     checks = 0;

    logic [6:0] good_ecc;
`ifdef JBI_IQ_ECC_CHK_EN
    logic [31:0] unused_pg;
    zzecc_sctag_pgen_32b u_tb_pgen (.dout(unused_pg), .parity(good_ecc), .din(jbi_sctag_req));
    localparam logic EXP_ECC = 1'b1;
`else
    assign good_ecc = 7'h00;
    localparam logic EXP_ECC = 1'b0;
`endif

    always #5 rclk = ~rclk;

    sctag_jbi_iq #(.IQ_DEPTH(IQ_DEPTH)) dut (
        .rclk(rclk), .arst_l(arst_l),
        .jbi_sctag_req_vld(jbi_sctag_req_vld), .jbi_sctag_req(jbi_sctag_req),
        .jbi_scbuf_ecc(jbi_scbuf_ecc), .sctag_jbi_iq_dequeue(sctag_jbi_iq_dequeue),
        .iq_vld(iq_vld), .iq_rdy(iq_rdy), .iq_opcode(iq_opcode), .iq_ctag(iq_ctag),
        .iq_addr(iq_addr), .iq_wdata(iq_wdata), .iq_ecc_err(iq_ecc_err), .iq_ovf_err(iq_ovf_err),
        .rtn_vld(rtn_vld), .rtn_rdy(rtn_rdy), .rtn_ctag(rtn_ctag), .rtn_data(rtn_data),
        .rtn_ue(rtn_ue), .scbuf_jbi_ctag_vld(scbuf_jbi_ctag_vld),
        .scbuf_jbi_data(scbuf_jbi_data), .scbuf_jbi_ue_err(scbuf_jbi_ue_err)
    );

    function automatic entry_t cur_head();
        return {iq_opcode, iq_ctag, iq_addr, iq_wdata, iq_ecc_err};
    endfunction

    // Entered and left one time unit after a rising edge.
    task automatic drive_beat(input logic [31:0] d, input logic [6:0] flip);
        jbi_sctag_req = d;
        #1;
        jbi_scbuf_ecc     = good_ecc ^ flip;
        jbi_sctag_req_vld = 1'b1;
        @(posedge rclk);
        #1;
        jbi_sctag_req_vld = 1'b0;
        jbi_sctag_req     = '0;
    endtask

    task automatic send_frame(input logic [1:0] op, input logic [11:0] ctag, input logic [31:0] addr,
                              input logic [63:0] wdata, input logic expect_enq);
        entry_t e;
        drive_beat({op, ctag, 18'h0}, 7'h0);
        drive_beat(addr, 7'h0);
        if (op == 2'b01) begin
            drive_beat(wdata[63:32], 7'h0);
            drive_beat(wdata[31:0], 7'h0);
        end
        if (expect_enq && !op[1]) begin
            e = '{opcode: op, ctag: ctag, addr: addr, wdata: (op == 2'b01) ? wdata : 64'h0, ecc_err: 1'b0};
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int cycles, output int n_deq);
        n_deq  = 0;
        iq_rdy = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (iq_vld) obs_q.push_back(cur_head());
            @(posedge rclk);
            #1;
            if (sctag_jbi_iq_dequeue) n_deq++;
        end
        iq_rdy = 1'b0;
    endtask

    task automatic test_reset();
        arst_l = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        checks++;
        if (iq_vld !== 1'b0 || sctag_jbi_iq_dequeue !== 1'b0 || iq_ovf_err !== 1'b0 || iq_ecc_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_iq: vld=%b deq=%b ovf=%b ecc=%b, required all 0",
                     iq_vld, sctag_jbi_iq_dequeue, iq_ovf_err, iq_ecc_err);
        end
        checks++;
        if (cur_head() !== '0) begin
            errors++;
            $display("FAIL reset_head: got %h, required 0", cur_head());
        end
        checks++;
        if (rtn_rdy !== 1'b1 || scbuf_jbi_ctag_vld !== 1'b0 || scbuf_jbi_data !== 32'h0 || scbuf_jbi_ue_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rtn: rdy=%b cv=%b data=%h ue=%b, required 1/0/0/0",
                     rtn_rdy, scbuf_jbi_ctag_vld, scbuf_jbi_data, scbuf_jbi_ue_err);
        end
        arst_l = 1'b1;
        @(posedge rclk);
        #1;
    endtask

    task automatic test_rd();
        entry_t e;
        iq_rdy = 1'b1;
        send_frame(2'b00, 12'h001, 32'h1234_5680, 64'h0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (iq_vld !== 1'b1 || cur_head() !== e) begin
            errors++;
            $display("FAIL rd_head: vld=%b head=%h, required 1 %h", iq_vld, cur_head(), e);
        end
        @(posedge rclk);
        #1;
        checks++;
        if (iq_vld !== 1'b0 || sctag_jbi_iq_dequeue !== 1'b1) begin
            errors++;
            $display("FAIL rd_pop: vld=%b deq=%b, required 0 1", iq_vld, sctag_jbi_iq_dequeue);
        end
        @(posedge rclk);
        #1;
        checks++;
        if (sctag_jbi_iq_dequeue !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse_width: deq=%b, required 0", sctag_jbi_iq_dequeue);
        end
        iq_rdy = 1'b0;
    endtask

    task automatic test_wr_gap();
        int n_deq;
        entry_t e, o;
        iq_rdy = 1'b0;
        drive_beat({2'b01, 12'h3C5, 18'h0}, 7'h0);
        drive_beat(32'h0000_2040, 7'h0);
        drive_beat(32'hDEAD_BEEF, 7'h0);
        repeat (2) begin
            @(posedge rclk);
            #1;
            checks++;
            if (iq_vld !== 1'b0) begin
                errors++;
                $display("FAIL wr_gap_hold: vld=%b, required 0", iq_vld);
            end
        end
        drive_beat(32'hCAFE_F00D, 7'h01);
        exp_q.push_back('{opcode: 2'b01, ctag: 12'h3C5, addr: 32'h0000_2040,
                          wdata: 64'hDEAD_BEEF_CAFE_F00D, ecc_err: EXP_ECC});
        drain(6, n_deq);
        checks++;
        if (n_deq != 1 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL wr_count: deq=%0d entries=%0d, required 1 1", n_deq, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wr_entry: got %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_overflow();
        int n_deq;
        entry_t e, o;
        iq_rdy = 1'b0;
        for (int i = 0; i <= IQ_DEPTH; i++)
            send_frame(2'b00, 12'h100 + 12'(i), 32'h8000_0000 + 32'(i * 64), 64'h0, i < IQ_DEPTH);
        checks++;
        if (iq_ovf_err !== 1'b1 || iq_vld !== 1'b1 || iq_ctag !== 12'h100) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b vld=%b ctag=%h, required 1 1 100", iq_ovf_err, iq_vld, iq_ctag);
        end
        drain(16, n_deq);
        checks++;
        if (n_deq != IQ_DEPTH || obs_q.size() != IQ_DEPTH) begin
            errors++;
            $display("FAIL ovf_credits: deq=%0d entries=%0d, required %0d", n_deq, obs_q.size(), IQ_DEPTH);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ovf_entry: got %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (iq_ovf_err !== 1'b1 || iq_vld !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b vld=%b, required 1 0", iq_ovf_err, iq_vld);
        end
    endtask

    task automatic test_reserved_pop();
        entry_t e;
        logic [2:0] pulses;
        iq_rdy = 1'b0;
        send_frame(2'b00, 12'h0AB, 32'h0000_0100, 64'h0, 1'b1);
        drive_beat({2'b10, 12'h7FF, 18'h0}, 7'h0);
        checks++;
        if (sctag_jbi_iq_dequeue !== 1'b0) begin
            errors++;
            $display("FAIL rsv_early: deq=%b, required 0", sctag_jbi_iq_dequeue);
        end
        e = exp_q.pop_front();
        checks++;
        if (iq_vld !== 1'b1 || cur_head() !== e) begin
            errors++;
            $display("FAIL rsv_head: vld=%b head=%h, required 1 %h", iq_vld, cur_head(), e);
        end
        iq_rdy = 1'b1;
        drive_beat(32'h0000_0200, 7'h0);
        iq_rdy = 1'b0;
        pulses[0] = sctag_jbi_iq_dequeue;
        @(posedge rclk);
        #1;
        pulses[1] = sctag_jbi_iq_dequeue;
        @(posedge rclk);
        #1;
        pulses[2] = sctag_jbi_iq_dequeue;
        checks++;
        if (pulses !== 3'b011 || iq_vld !== 1'b0) begin
            errors++;
            $display("FAIL rsv_credits: pulses(t2..t0)=%b vld=%b, required 011 0", pulses, iq_vld);
        end
    endtask

    task automatic test_back_to_back();
        beat_t b;
        ret_q.push_back('{1'b1, 32'h0000_00AA, 1'b0});
        ret_q.push_back('{1'b0, 32'h1111_2222, 1'b1});
        ret_q.push_back('{1'b0, 32'h3333_4444, 1'b1});
        ret_q.push_back('{1'b1, 32'h0000_0055, 1'b0});
        ret_q.push_back('{1'b0, 32'h5566_7788, 1'b0});
        ret_q.push_back('{1'b0, 32'h99AA_BBCC, 1'b0});
        ret_q.push_back('{1'b0, 32'h0000_0000, 1'b0});
        rtn_vld = 1'b1; rtn_ctag = 12'h0AA; rtn_data = 64'h1111_2222_3333_4444; rtn_ue = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge rclk);
            #1;
            if (i == 0) begin
                rtn_ctag = 12'h055; rtn_data = 64'h5566_7788_99AA_BBCC; rtn_ue = 1'b0;
                checks++;
                if (rtn_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL rtn_busy: rdy=%b, required 0", rtn_rdy);
                end
            end
            if (i == 3) rtn_vld = 1'b0;
            b = ret_q.pop_front();
            checks++;
            if (scbuf_jbi_ctag_vld !== b.vld || scbuf_jbi_data !== b.data || scbuf_jbi_ue_err !== b.ue) begin
                errors++;
                $display("FAIL rtn_beat%0d: cv=%b data=%h ue=%b, required %b %h %b", i,
                         scbuf_jbi_ctag_vld, scbuf_jbi_data, scbuf_jbi_ue_err, b.vld, b.data, b.ue);
            end
        end
    endtask

    task automatic test_reset_mid_wr();
        int n_deq;
        entry_t e, o;
        iq_rdy = 1'b0;
        drive_beat({2'b01, 12'h0F0, 18'h0}, 7'h0);
        drive_beat(32'h0000_3000, 7'h0);
        drive_beat(32'h0BAD_0BAD, 7'h0);
        arst_l = 1'b0;
        #2;
        checks++;
        if (iq_vld !== 1'b0 || iq_ovf_err !== 1'b0 || sctag_jbi_iq_dequeue !== 1'b0 || rtn_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: vld=%b ovf=%b deq=%b rdy=%b, required 0 0 0 1",
                     iq_vld, iq_ovf_err, sctag_jbi_iq_dequeue, rtn_rdy);
        end
        @(posedge rclk);
        #1;
        arst_l = 1'b1;
        send_frame(2'b00, 12'h222, 32'h0000_4440, 64'h0, 1'b1);
        drain(6, n_deq);
        checks++;
        if (n_deq != 1 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_count: deq=%0d entries=%0d, required 1 1", n_deq, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midreset_entry: got %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rd();
        test_wr_gap();
        test_overflow();
        test_reserved_pop();
        test_back_to_back();
        test_reset_mid_wr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
